// File: rtl/osc_signal_gen_if.sv
// Configuration and status bundle for the OSC/index line generator.
// master drives configuration, slave is the generator itself.
interface osc_signal_gen_if #(
  parameter int CNT_W    = 16,
  parameter int GLITCH_W = 4
);
  logic                enable;
  logic [CNT_W-1:0]    high_len;
  logic [CNT_W-1:0]    low_len;
  logic                glitch_en;
  logic [CNT_W-1:0]    glitch_pos;
  logic [GLITCH_W-1:0] glitch_len;
  logic                sig_out;
  logic                period_done;
  logic                busy;

  modport master (
    output enable,
    output high_len,
    output low_len,
    output glitch_en,
    output glitch_pos,
    output glitch_len,
    input  sig_out,
    input  period_done,
    input  busy
  );

  modport slave (
    input  enable,
    input  high_len,
    input  low_len,
    input  glitch_en,
    input  glitch_pos,
    input  glitch_len,
    output sig_out,
    output period_done,
    output busy
  );
endinterface

// File: rtl/osc_signal_gen.sv
// OSC/index line transmitter: periodic square wave with tick-based
// high/low phases and optional in-phase glitch injection.
module osc_signal_gen #(
  parameter int CNT_W    = 16,
  parameter int TICK_DIV = 256,
  parameter int GLITCH_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  osc_signal_gen_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [GLITCH_W-1:0] G_ONE = GLITCH_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t              state;
  logic [PW-1:0]       pre;
  logic [CNT_W-1:0]    tick_cnt;
  logic [GLITCH_W-1:0] gcnt;

  logic [CNT_W-1:0]    sh_high;
  logic [CNT_W-1:0]    sh_low;
  logic                sh_gen;
  logic [CNT_W-1:0]    sh_gpos;
  logic [GLITCH_W-1:0] sh_glen;

  logic                sig_q;
  logic                pd_q;
  logic                busy_q;

  logic [CNT_W-1:0]    eff_high;
  logic [CNT_W-1:0]    eff_low;
  logic [CNT_W-1:0]    cur_len;
  logic [CNT_W-1:0]    nxt_tick;
  logic [PW-1:0]       nxt_pre;
  logic                tick;
  logic                phase_end;
  logic                g_ok;
  logic                g_mid;
  logic                g_hold;
  logic                g_in0;
  logic                g_sh0;
  logic [GLITCH_W-1:0] g_in_cnt;
  logic [GLITCH_W-1:0] g_sh_cnt;

  // Phase length, tick and glitch-start decode for the current cycle
  always_comb begin
    eff_high  = (sh_high == '0) ? ONE : sh_high;
    eff_low   = (sh_low == '0) ? ONE : sh_low;
    cur_len   = (state == HIGH) ? eff_high : eff_low;
    tick      = (pre == PRE_MAX);
    phase_end = (state != IDLE) && tick &&
                (tick_cnt == cur_len - ONE);
    nxt_pre   = tick ? '0 : pre + 1'b1;
    nxt_tick  = tick ? tick_cnt + ONE : tick_cnt;
    g_ok      = sh_gen && (sh_glen != '0) &&
                (sh_gpos < cur_len);
    g_mid     = g_ok && tick && (nxt_tick == sh_gpos);
    g_hold    = (gcnt != '0);
    // A glitch at tick 0 has to start on the phase entry edge itself
    g_in0     = bus.glitch_en && (bus.glitch_len != '0) &&
                (bus.glitch_pos == '0);
    g_sh0     = sh_gen && (sh_glen != '0) && (sh_gpos == '0);
    g_in_cnt  = g_in0 ? bus.glitch_len - G_ONE : '0;
    g_sh_cnt  = g_sh0 ? sh_glen - G_ONE : '0;
  end

  // Period sequencing, phase timing, glitch overlay and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pre      <= '0;
      tick_cnt <= '0;
      gcnt     <= '0;
      sh_high  <= '0;
      sh_low   <= '0;
      sh_gen   <= 1'b0;
      sh_gpos  <= '0;
      sh_glen  <= '0;
      sig_q    <= 1'b0;
      pd_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      pd_q <= 1'b0;
      unique case (state)
        IDLE: begin
          pre      <= '0;
          tick_cnt <= '0;
          gcnt     <= '0;
          if (bus.enable) begin
            state   <= HIGH;
            busy_q  <= 1'b1;
            sh_high <= bus.high_len;
            sh_low  <= bus.low_len;
            sh_gen  <= bus.glitch_en;
            sh_gpos <= bus.glitch_pos;
            sh_glen <= bus.glitch_len;
            sig_q   <= ~g_in0;
            gcnt    <= g_in_cnt;
          end
        end
        HIGH: begin
          if (phase_end) begin
            state    <= LOW;
            pre      <= '0;
            tick_cnt <= '0;
            sig_q    <= g_sh0;
            gcnt     <= g_sh_cnt;
          end else begin
            pre      <= nxt_pre;
            tick_cnt <= nxt_tick;
            if (g_mid) begin
              sig_q <= 1'b0;
              gcnt  <= sh_glen - G_ONE;
            end else if (g_hold) begin
              sig_q <= 1'b0;
              gcnt  <= gcnt - G_ONE;
            end else begin
              sig_q <= 1'b1;
            end
          end
        end
        LOW: begin
          if (phase_end) begin
            pd_q     <= 1'b1;
            pre      <= '0;
            tick_cnt <= '0;
            if (bus.enable) begin
              state   <= HIGH;
              sh_high <= bus.high_len;
              sh_low  <= bus.low_len;
              sh_gen  <= bus.glitch_en;
              sh_gpos <= bus.glitch_pos;
              sh_glen <= bus.glitch_len;
              sig_q   <= ~g_in0;
              gcnt    <= g_in_cnt;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
              sig_q  <= 1'b0;
              gcnt   <= '0;
            end
          end else begin
            pre      <= nxt_pre;
            tick_cnt <= nxt_tick;
            if (g_mid) begin
              sig_q <= 1'b1;
              gcnt  <= sh_glen - G_ONE;
            end else if (g_hold) begin
              sig_q <= 1'b1;
              gcnt  <= gcnt - G_ONE;
            end else begin
              sig_q <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          sig_q  <= 1'b0;
          gcnt   <= '0;
        end
      endcase
    end
  end

  assign bus.sig_out     = sig_q;
  assign bus.period_done = pd_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_osc_signal_gen.sv
// Bench for osc_signal_gen: waveform model plus directed
// literal checks and a randomized configuration run.
module tb_osc_signal_gen;
  localparam int CNT_W = 16;
  localparam int TD    = 4;
  localparam int GW    = 4;

  logic clk;
  logic rst_n;

  osc_signal_gen_if #(.CNT_W(CNT_W), .GLITCH_W(GW)) bus();

  osc_signal_gen #(
    .CNT_W(CNT_W),
    .TICK_DIV(TD),
    .GLITCH_W(GW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  // model: position in the current period plus the latched config
  bit m_run = 0;
  bit m_pd  = 0;
  int m_t   = 0;
  int m_h   = 1;
  int m_l   = 1;
  bit m_ge  = 0;
  int m_gp  = 0;
  int m_gl  = 0;

  logic s_sig[0:63];
  logic s_pd[0:63];
  logic s_busy[0:63];

  task automatic check(input string name, input logic got,
                       input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t",
               name, got, exp, $time);
    end
  endtask

  function automatic int eff(input logic [CNT_W-1:0] v);
    return (v == '0) ? 1 : int'(v);
  endfunction

  task automatic latch_cfg();
    m_h  = eff(bus.high_len);
    m_l  = eff(bus.low_len);
    m_ge = bus.glitch_en;
    m_gp = int'(bus.glitch_pos);
    m_gl = int'(bus.glitch_len);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0;
      m_pd  = 0;
      m_t   = 0;
    end else if (!m_run) begin
      m_pd = 0;
      if (bus.enable) begin
        m_run = 1;
        m_t   = 0;
        latch_cfg();
      end
    end else begin
      m_t++;
      m_pd = 0;
      if (m_t == (m_h + m_l) * TD) begin
        m_pd = 1;
        if (bus.enable) begin
          m_t = 0;
          latch_cfg();
        end else begin
          m_run = 0;
        end
      end
    end
  end

  function automatic logic exp_sig();
    int u;
    int plen;
    logic base;
    if (!m_run) return 1'b0;
    if (m_t < m_h * TD) begin
      base = 1'b1;
      u    = m_t;
      plen = m_h;
    end else begin
      base = 1'b0;
      u    = m_t - m_h * TD;
      plen = m_l;
    end
    if (m_ge && m_gl != 0 && m_gp < plen &&
        u >= m_gp * TD && u < m_gp * TD + m_gl)
      return ~base;
    return base;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check("sig_out", bus.sig_out, exp_sig());
      check("period_done", bus.period_done, m_pd);
      check("busy", bus.busy, m_run);
    end
  end

  task automatic set_cfg(input int h, input int l, input bit ge,
                         input int gp, input int gl);
    bus.high_len   = CNT_W'(h);
    bus.low_len    = CNT_W'(l);
    bus.glitch_en  = ge;
    bus.glitch_pos = CNT_W'(gp);
    bus.glitch_len = GW'(gl);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", bus.busy, 1'b0);
  endtask

  task automatic capture(input int n, input int drop_at,
                         input int hl_at, input int hl_val);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      s_sig[k]  = bus.sig_out;
      s_pd[k]   = bus.period_done;
      s_busy[k] = bus.busy;
      if (k == drop_at) bus.enable = 1'b0;
      if (k == hl_at) bus.high_len = CNT_W'(hl_val);
    end
  endtask

  initial begin
    int hi_cnt;
    rst_n = 1'b0;
    bus.enable = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_sig", bus.sig_out, 1'b0);
    check("rst_pd", bus.period_done, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    chk_on = 1;
    #2 rst_n = 1'b1;

    // basic 2/3 period, high_len raised to 5 mid-HIGH
    @(negedge clk);
    set_cfg(2, 3, 0, 0, 0);
    bus.enable = 1'b1;
    capture(60, -1, 3, 5);
    hi_cnt = 0;
    for (int k = 0; k < 20; k++) hi_cnt += int'(s_sig[k]);
    checks++;
    if (hi_cnt != 8) begin
      errors++;
      $display("FAIL s1_high_count: got %0d expected 8", hi_cnt);
    end
    check("s1_sig0", s_sig[0], 1'b1);
    check("s1_pd0", s_pd[0], 1'b0);
    check("s1_sig7", s_sig[7], 1'b1);
    check("s1_sig8", s_sig[8], 1'b0);
    check("s1_sig19", s_sig[19], 1'b0);
    check("s1_pd19", s_pd[19], 1'b0);
    check("s1_pd20", s_pd[20], 1'b1);
    check("s1_sig20", s_sig[20], 1'b1);
    check("s5_sig39", s_sig[39], 1'b1);
    check("s5_sig40", s_sig[40], 1'b0);
    check("s5_pd40", s_pd[40], 1'b0);
    check("s5_pd52", s_pd[52], 1'b1);

    // zero lengths behave as one tick
    set_cfg(0, 0, 0, 0, 0);
    repeat (40) @(negedge clk);

    // enable dropped at clk 3 of HIGH
    bus.enable = 1'b0;
    wait_idle();
    set_cfg(2, 3, 0, 0, 0);
    bus.enable = 1'b1;
    capture(24, 3, -1, 0);
    check("s3_sig7", s_sig[7], 1'b1);
    check("s3_sig8", s_sig[8], 1'b0);
    check("s3_busy19", s_busy[19], 1'b1);
    check("s3_pd20", s_pd[20], 1'b1);
    check("s3_sig20", s_sig[20], 1'b0);
    check("s3_busy20", s_busy[20], 1'b0);
    check("s3_busy21", s_busy[21], 1'b0);

    // glitch pos 1 len 2 in both 3-tick phases
    wait_idle();
    set_cfg(3, 3, 1, 1, 2);
    bus.enable = 1'b1;
    capture(24, 0, -1, 0);
    check("s4_sig3", s_sig[3], 1'b1);
    check("s4_sig4", s_sig[4], 1'b0);
    check("s4_sig5", s_sig[5], 1'b0);
    check("s4_sig6", s_sig[6], 1'b1);
    check("s4_sig15", s_sig[15], 1'b0);
    check("s4_sig16", s_sig[16], 1'b1);
    check("s4_sig17", s_sig[17], 1'b1);
    check("s4_sig18", s_sig[18], 1'b0);

    // reset pulsed mid-LOW
    wait_idle();
    set_cfg(2, 3, 0, 0, 0);
    bus.enable = 1'b1;
    capture(12, -1, -1, 0);
    check("s6_pre_sig", s_sig[11], 1'b0);
    check("s6_pre_busy", s_busy[11], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("s6_async_sig", bus.sig_out, 1'b0);
    check("s6_async_busy", bus.busy, 1'b0);
    check("s6_async_pd", bus.period_done, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("s6_restart_sig", bus.sig_out, 1'b1);
    check("s6_restart_busy", bus.busy, 1'b1);

    // randomized configuration, enable and reset activity
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0)
        set_cfg($urandom_range(0, 4), $urandom_range(0, 4),
                1'($urandom_range(0, 1)), $urandom_range(0, 4),
                $urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0)
        bus.enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
